// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I main control FSM:
// opcodes, state enum, datapath select encodings and the control vector.
package rv32i_ctrl_pkg;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StMemAddr, StMemRd, StMemWr, StWbAlu,
        StWbMem, StBranch, StJal, StJalr, StLui, StAuipc, StTrap
    } state_e;

    typedef enum logic [1:0] {AluOpAdd = 2'b00, AluOpBranch = 2'b01, AluOpFunct = 2'b10} alu_op_e;
    typedef enum logic [1:0] {PcSrcAlu = 2'b00, PcSrcAluOut = 2'b01, PcSrcJalr = 2'b10} pc_src_e;
    typedef enum logic [1:0] {WbAluOut = 2'b00, WbMdr = 2'b01, WbPc = 2'b10} wb_sel_e;
    typedef enum logic [1:0] {
        AluAPc = 2'b00, AluARs1 = 2'b01, AluAOldPc = 2'b10, AluAZero = 2'b11
    } alu_src_a_e;
    typedef enum logic [1:0] {AluBRs2 = 2'b00, AluBFour = 2'b01, AluBImm = 2'b10} alu_src_b_e;
    typedef enum logic [1:0] {
        TrapNone = 2'b00, TrapIllegal = 2'b01, TrapTimeout = 2'b10
    } trap_cause_e;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        addr_sel;
        logic        ir_write;
        logic        pc_write;
        pc_src_e     pc_src;
        logic        reg_write;
        wb_sel_e     wb_sel;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
        logic        trap;
        trap_cause_e trap_cause;
    } ctrl_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state -> control-vector decoder; only mem_ready and
// branch_taken gate individual enables.
module ctrl_out_decode
    import rv32i_ctrl_pkg::*;
(
    input  state_e      state_i,
    input  logic        mem_ready_i,
    input  logic        branch_taken_i,
    input  trap_cause_e cause_i,
    output ctrl_t       ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            StFetch: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.alu_src_a = AluAPc;
                ctrl_o.alu_src_b = AluBFour;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
                ctrl_o.pc_src    = PcSrcAlu;
            end
            StDecode, StAuipc: begin
                ctrl_o.alu_src_a = AluAOldPc;
                ctrl_o.alu_src_b = AluBImm;
            end
            StExecR: begin
                ctrl_o.alu_src_a = AluARs1;
                ctrl_o.alu_src_b = AluBRs2;
                ctrl_o.alu_op    = AluOpFunct;
            end
            StExecI: begin
                ctrl_o.alu_src_a = AluARs1;
                ctrl_o.alu_src_b = AluBImm;
                ctrl_o.alu_op    = AluOpFunct;
            end
            StLui: begin
                ctrl_o.alu_src_a = AluAZero;
                ctrl_o.alu_src_b = AluBImm;
            end
            StMemAddr: begin
                ctrl_o.alu_src_a = AluARs1;
                ctrl_o.alu_src_b = AluBImm;
            end
            StMemRd: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.addr_sel = 1'b1;
            end
            StMemWr: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.mem_we   = 1'b1;
                ctrl_o.addr_sel = 1'b1;
            end
            StWbAlu: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wb_sel    = WbAluOut;
            end
            StWbMem: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wb_sel    = WbMdr;
            end
            StBranch: begin
                ctrl_o.alu_src_a = AluARs1;
                ctrl_o.alu_src_b = AluBRs2;
                ctrl_o.alu_op    = AluOpBranch;
                ctrl_o.pc_src    = PcSrcAluOut;
                ctrl_o.pc_write  = branch_taken_i;
            end
            StJal: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wb_sel    = WbPc;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_src    = PcSrcAluOut;
            end
            StJalr: begin
                // Register file captures the pre-edge PC (PC+4) while PC loads the target.
                ctrl_o.alu_src_a = AluARs1;
                ctrl_o.alu_src_b = AluBImm;
                ctrl_o.pc_src    = PcSrcJalr;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wb_sel    = WbPc;
            end
            StTrap: begin
                ctrl_o.trap       = 1'b1;
                ctrl_o.trap_cause = cause_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: state register, next-state
// dispatch, sticky trap cause and the memory-wait watchdog.
module multicycle_main_ctrl
    import rv32i_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALU_OP,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLimit = CntW'(MEM_TIMEOUT);
    localparam logic WdogEn = (MEM_TIMEOUT != 0);

    state_e          state_q, state_d;
    trap_cause_e     cause_q, cause_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    ctrl_t           ctrl_raw, ctrl;
    logic            waiting, timeout;

    ctrl_out_decode u_decode (
        .state_i        (state_q),
        .mem_ready_i    (mem_ready),
        .branch_taken_i (branch_taken),
        .cause_i        (cause_q),
        .ctrl_o         (ctrl_raw)
    );

    assign waiting = ctrl_raw.mem_req && !mem_ready;
    // A ready on the limit cycle still completes the access.
    assign timeout = WdogEn && waiting && (cnt_q == CntLimit);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            StFetch:   if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpcOp:              state_d = StExecR;
                    OpcOpImm:           state_d = StExecI;
                    OpcLoad, OpcStore:  state_d = StMemAddr;
                    OpcBranch:          state_d = StBranch;
                    OpcJal:             state_d = StJal;
                    OpcJalr:            state_d = StJalr;
                    OpcLui:             state_d = StLui;
                    OpcAuipc:           state_d = StAuipc;
                    default: begin
                        state_d = StTrap;
                        cause_d = TrapIllegal;
                    end
                endcase
            end
            StExecR, StExecI, StLui, StAuipc: state_d = StWbAlu;
            StMemAddr: state_d = opcode[5] ? StMemWr : StMemRd;
            StMemRd:   if (mem_ready) state_d = StWbMem;
            StMemWr:   if (mem_ready) state_d = StFetch;
            StWbAlu, StWbMem, StBranch, StJal, StJalr: state_d = StFetch;
            StTrap:    state_d = StTrap;
            default:   state_d = StTrap;
        endcase
        if (timeout) begin
            state_d = StTrap;
            cause_d = TrapTimeout;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (WdogEn && waiting) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cause_q <= TrapNone;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset silences every output, aborting any in-flight request.
    assign ctrl = rst ? '0 : ctrl_raw;

    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign addr_sel   = ctrl.addr_sel;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign pc_src     = ctrl.pc_src;
    assign reg_write  = ctrl.reg_write;
    assign wb_sel     = ctrl.wb_sel;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign ALU_OP     = ctrl.alu_op;
    assign trap       = ctrl.trap;
    assign trap_cause = ctrl.trap_cause;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Self-checking bench: per-cycle expected control vectors are queued as stimulus
// is driven and popped when the outputs are sampled mid-cycle.
module tb_multicycle_main_ctrl;

    typedef enum {BF, BD, BER, BEI, BMA, BMR, BMW, BWA, BWM, BBR, BJAL, BJALR, BLUI, BAUIPC,
                  BTRAP, BRST} bst_e;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'h00;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write, trap;
    logic [1:0] pc_src, wb_sel, alu_src_a, alu_src_b, ALU_OP, trap_cause;

    int          checks = 0;
    int          failures = 0;
    logic [1:0]  exp_cause = 2'b00;
    logic [18:0] sb[$];
    logic [18:0] want;
    logic [18:0] act;

    always #5 clk = ~clk;

    multicycle_main_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .ALU_OP       (ALU_OP),
        .trap         (trap),
        .trap_cause   (trap_cause)
    );

    assign act = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write, wb_sel,
                  alu_src_a, alu_src_b, ALU_OP, trap, trap_cause};

    // Expected outputs for a state, straight from the per-state output table.
    function automatic logic [18:0] model(input bst_e s, input logic rdy, input logic bt);
        logic req = 0, we = 0, as = 0, irw = 0, pcw = 0, rw = 0, tr = 0;
        logic [1:0] pcs = 0, wb = 0, a = 0, b = 0, op = 0, tc = 0;
        case (s)
            BF:     begin req = 1; b = 2'b01; irw = rdy; pcw = rdy; end
            BD:     begin a = 2'b10; b = 2'b10; end
            BER:    begin a = 2'b01; b = 2'b00; op = 2'b10; end
            BEI:    begin a = 2'b01; b = 2'b10; op = 2'b10; end
            BLUI:   begin a = 2'b11; b = 2'b10; end
            BAUIPC: begin a = 2'b10; b = 2'b10; end
            BMA:    begin a = 2'b01; b = 2'b10; end
            BMR:    begin req = 1; as = 1; end
            BMW:    begin req = 1; as = 1; we = 1; end
            BWA:    begin rw = 1; wb = 2'b00; end
            BWM:    begin rw = 1; wb = 2'b01; end
            BBR:    begin a = 2'b01; op = 2'b01; pcs = 2'b01; pcw = bt; end
            BJAL:   begin rw = 1; wb = 2'b10; pcw = 1; pcs = 2'b01; end
            BJALR:  begin a = 2'b01; b = 2'b10; pcs = 2'b10; pcw = 1; rw = 1; wb = 2'b10; end
            BTRAP:  begin tr = 1; tc = exp_cause; end
            default: ;
        endcase
        return {req, we, as, irw, pcw, pcs, rw, wb, a, b, op, tr, tc};
    endfunction

    task automatic drive(input bst_e s, input logic rdy, input logic bt);
        @(negedge clk);
        rst = (s == BRST);
        mem_ready = rdy;
        branch_taken = bt;
        sb.push_back(model(s, rdy, bt));
        #3;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(BRST, 1'b1, 1'b1);
            want = sb.pop_front();
            checks++;
            if (act !== want) begin
                failures++;
                $display("FAIL reset[%0d] got=%05h want=%05h", i, act, want);
            end
        end
    endtask

    task automatic test_add();
        bst_e seq[4] = '{BF, BD, BER, BWA};
        opcode = 7'h33;
        foreach (seq[i]) begin
            drive(seq[i], 1'b1, 1'b0);
            want = sb.pop_front();
            checks++;
            if (act !== want) begin
                failures++;
                $display("FAIL add[%0d] got=%05h want=%05h", i, act, want);
            end
        end
    endtask

    task automatic test_other_ops();
        logic [6:0] ops[6] = '{7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h23};
        bst_e mids[6] = '{BEI, BLUI, BAUIPC, BJAL, BJALR, BMA};
        bst_e lasts[6] = '{BWA, BWA, BWA, BF, BF, BMW};
        logic four[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            bst_e q[$];
            q = '{BF, BD, mids[k]};
            if (four[k]) q.push_back(lasts[k]);
            opcode = ops[k];
            foreach (q[i]) begin
                drive(q[i], 1'b1, 1'b0);
                want = sb.pop_front();
                checks++;
                if (act !== want) begin
                    failures++;
                    $display("FAIL op%02h[%0d] got=%05h want=%05h", ops[k], i, act, want);
                end
            end
        end
    endtask

    task automatic test_load_wait();
        bst_e seq[8] = '{BF, BD, BMA, BMR, BMR, BMR, BMR, BWM};
        logic rdy[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 7'h03;
        foreach (seq[i]) begin
            drive(seq[i], rdy[i], 1'b0);
            want = sb.pop_front();
            checks++;
            if (act !== want) begin
                failures++;
                $display("FAIL load[%0d] got=%05h want=%05h", i, act, want);
            end
        end
    endtask

    task automatic test_branch();
        opcode = 7'h63;
        for (int t = 1; t >= 0; t--) begin
            bst_e seq[3] = '{BF, BD, BBR};
            foreach (seq[i]) begin
                drive(seq[i], 1'b1, t[0]);
                want = sb.pop_front();
                checks++;
                if (act !== want) begin
                    failures++;
                    $display("FAIL beq_t%0d[%0d] got=%05h want=%05h", t, i, act, want);
                end
            end
        end
    endtask

    task automatic test_illegal();
        bst_e q[$];
        q = '{BF, BD};
        for (int i = 0; i < 20; i++) q.push_back(BTRAP);
        q.push_back(BRST);
        opcode = 7'h7F;
        exp_cause = 2'b01;
        foreach (q[i]) begin
            drive(q[i], 1'b1, 1'b0);
            want = sb.pop_front();
            checks++;
            if (act !== want) begin
                failures++;
                $display("FAIL illegal[%0d] got=%05h want=%05h", i, act, want);
            end
        end
    endtask

    task automatic test_timeout();
        bst_e seq[8] = '{BF, BF, BF, BF, BF, BTRAP, BTRAP, BRST};
        exp_cause = 2'b10;
        foreach (seq[i]) begin
            drive(seq[i], 1'b0, 1'b0);
            want = sb.pop_front();
            checks++;
            if (act !== want) begin
                failures++;
                $display("FAIL timeout[%0d] got=%05h want=%05h", i, act, want);
            end
        end
    endtask

    task automatic test_ready_at_limit();
        bst_e seq[8] = '{BF, BF, BF, BF, BF, BD, BER, BWA};
        logic rdy[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        opcode = 7'h33;
        foreach (seq[i]) begin
            drive(seq[i], rdy[i], 1'b0);
            want = sb.pop_front();
            checks++;
            if (act !== want) begin
                failures++;
                $display("FAIL limit[%0d] got=%05h want=%05h", i, act, want);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        bst_e seq[8] = '{BF, BD, BMA, BMW, BMW, BRST, BF, BF};
        logic rdy[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        opcode = 7'h23;
        foreach (seq[i]) begin
            drive(seq[i], rdy[i], 1'b0);
            want = sb.pop_front();
            checks++;
            if (act !== want) begin
                failures++;
                $display("FAIL rst_store[%0d] got=%05h want=%05h", i, act, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_other_ops();
        test_load_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_ready_at_limit();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
